pdm_capture_ctrl: RTL and testbench

//   Sequencer for the PDM microphone front end. Generates the mic clock and the sample strobe,
//   and discards a warm-up interval after every start or rate change. It then pulses the

---
 rtl/pdm_capture_ctrl.sv | 98 +++++++++
 tb/tb_pdm_capture_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/pdm_capture_ctrl.sv
// PDM microphone front-end sequencer: mic clock divider, warm-up discard, and
// glitch-free start/stop/rate-change control feeding the accumulator chain.
module pdm_capture_ctrl #(
  parameter int WARMUP_BITS    = 16,
  parameter int WARMUP_PERIODS = 1024
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       mode_req,
  output logic       pdm_clk,
  output logic       pdm_sample_valid,
  output logic       mode,
  output logic       accum_sync,
  output logic       capture_en,
  output logic       busy,
  output logic [1:0] state
);

  typedef enum logic [1:0] {IDLE = 2'd0, WARMUP = 2'd1, RUN = 2'd2, STOP = 2'd3} state_t;

  localparam logic [WARMUP_BITS-1:0] WARM_LAST = WARMUP_BITS'(WARMUP_PERIODS - 1);

  state_t                 st;
  logic [6:0]             cnt;
  logic [WARMUP_BITS-1:0] warm_cnt;
  logic                   period_end;
  logic                   abort;

  // Divider taps come straight off registered bits so the mic clock never glitches.
  assign pdm_clk          = mode ? cnt[5] : cnt[6];
  assign pdm_sample_valid = mode ? cnt[4] : cnt[5];
  assign period_end       = mode ? (cnt[5:0] == 6'd63) : (cnt == 7'd127);
  assign abort            = !enable || (mode_req != mode);
  assign state            = st;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st         <= IDLE;
      cnt        <= '0;
      warm_cnt   <= '0;
      mode       <= 1'b0;
      accum_sync <= 1'b0;
      capture_en <= 1'b0;
      busy       <= 1'b0;
    end else begin
      accum_sync <= 1'b0;
      case (st)
        IDLE: begin
          cnt <= '0;
          if (enable) begin
            st       <= WARMUP;
            mode     <= mode_req;
            warm_cnt <= '0;
            busy     <= 1'b1;
          end
        end
        WARMUP: begin
          cnt <= cnt + 7'd1;
          if (period_end) warm_cnt <= warm_cnt + WARMUP_BITS'(1);
          // Abort wins over a coincident warm-up completion.
          if (abort) begin
            st <= STOP;
          end else if (period_end && warm_cnt == WARM_LAST) begin
            st         <= RUN;
            accum_sync <= 1'b1;
            capture_en <= 1'b1;
          end
        end
        RUN: begin
          cnt <= cnt + 7'd1;
          if (abort) begin
            st         <= STOP;
            capture_en <= 1'b0;
          end
        end
        STOP: begin
          // Let the current mic clock period complete before parking low.
          if (period_end) begin
            cnt      <= '0;
            warm_cnt <= '0;
            if (enable) begin
              st   <= WARMUP;
              mode <= mode_req;
            end else begin
              st   <= IDLE;
              busy <= 1'b0;
            end
          end else begin
            cnt <= cnt + 7'd1;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pdm_capture_ctrl.sv
// Directed bench for pdm_capture_ctrl with a 4-period warm-up.
module tb_pdm_capture_ctrl;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic       mode_req;
  logic       pdm_clk, pdm_sample_valid, mode, accum_sync, capture_en, busy;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;

  pdm_capture_ctrl #(.WARMUP_BITS(16), .WARMUP_PERIODS(4)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .mode_req(mode_req),
    .pdm_clk(pdm_clk), .pdm_sample_valid(pdm_sample_valid), .mode(mode),
    .accum_sync(accum_sync), .capture_en(capture_en), .busy(busy), .state(state)
  );

  always #5 clk = ~clk;

  // Advance one clock; outputs are observed 1ns after the edge.
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; enable = 1'b0; mode_req = 1'b0;
    #1;
    checks++;
    if ({pdm_clk, pdm_sample_valid, mode, accum_sync, capture_en, busy, state} !== 8'b0) begin
      errors++;
      $display("FAIL reset_outputs got=%b want=00000000",
               {pdm_clk, pdm_sample_valid, mode, accum_sync, capture_en, busy, state});
    end
    tick(2);
    rst_n = 1'b1;
    tick(2);
    checks++;
    if (state !== 2'd0 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_idle state=%0d busy=%b want 0/0", state, busy);
    end
  endtask

  // Scenario 1: start in mode 0, 64 low / 64 high, accum_sync at 512 clks.
  task automatic test_start;
    enable = 1'b1; mode_req = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b1 || state !== 2'd1 || mode !== 1'b0) begin
      errors++; $display("FAIL start_entry busy=%b state=%0d mode=%b want 1/1/0", busy, state, mode);
    end
    for (int k = 0; k < 512; k++) begin
      checks++;
      if (pdm_clk !== ((k % 128) >= 64) || pdm_sample_valid !== ((k % 64) >= 32) ||
          accum_sync !== 1'b0 || capture_en !== 1'b0 || state !== 2'd1) begin
        errors++;
        $display("FAIL start_warmup k=%0d clk=%b sv=%b sync=%b cap=%b state=%0d", k, pdm_clk,
                 pdm_sample_valid, accum_sync, capture_en, state);
      end
      tick();
    end
    checks++;
    if (accum_sync !== 1'b1 || capture_en !== 1'b1 || state !== 2'd2) begin
      errors++; $display("FAIL start_run sync=%b cap=%b state=%0d want 1/1/2", accum_sync, capture_en, state);
    end
    tick();
    checks++;
    if (accum_sync !== 1'b0 || capture_en !== 1'b1) begin
      errors++; $display("FAIL start_pulse_width sync=%b cap=%b want 0/1", accum_sync, capture_en);
    end
  endtask

  // Scenario 2: currently at RUN cnt=1; request mode 1 at cnt=10.
  task automatic test_rate_change;
    tick(9);
    mode_req = 1'b1;
    tick();
    checks++;
    if (state !== 2'd3 || capture_en !== 1'b0 || mode !== 1'b0) begin
      errors++; $display("FAIL rate_stop state=%0d cap=%b mode=%b want 3/0/0", state, capture_en, mode);
    end
    for (int c = 11; c <= 127; c++) begin
      checks++;
      if (pdm_clk !== (c >= 64) || state !== 2'd3) begin
        errors++; $display("FAIL rate_finish_period cnt=%0d clk=%b state=%0d", c, pdm_clk, state);
      end
      tick();
    end
    checks++;
    if (state !== 2'd1 || mode !== 1'b1 || pdm_clk !== 1'b0) begin
      errors++; $display("FAIL rate_rewarm state=%0d mode=%b clk=%b want 1/1/0", state, mode, pdm_clk);
    end
    for (int k = 0; k < 256; k++) begin
      checks++;
      if (pdm_clk !== ((k % 64) >= 32) || pdm_sample_valid !== ((k % 32) >= 16) || accum_sync !== 1'b0) begin
        errors++;
        $display("FAIL rate_warmup k=%0d clk=%b sv=%b sync=%b", k, pdm_clk, pdm_sample_valid, accum_sync);
      end
      tick();
    end
    checks++;
    if (accum_sync !== 1'b1 || state !== 2'd2) begin
      errors++; $display("FAIL rate_sync sync=%b state=%0d want 1/2", accum_sync, state);
    end
  endtask

  task automatic go_idle;
    int n;
    enable = 1'b0;
    n = 0;
    while (state !== 2'd0 && n < 300) begin
      tick();
      n++;
    end
    checks++;
    if (state !== 2'd0) begin
      errors++; $display("FAIL go_idle_timeout state=%0d want 0", state);
    end
  endtask

  // Scenario 3: abort during WARMUP at cnt=200 (7-bit 72).
  task automatic test_abort;
    mode_req = 1'b0; enable = 1'b1;
    tick();
    tick(200);
    enable = 1'b0;
    tick();
    for (int i = 0; i < 55; i++) begin
      checks++;
      if (state !== 2'd3 || accum_sync !== 1'b0 || pdm_clk !== 1'b1) begin
        errors++; $display("FAIL abort_stop i=%0d state=%0d sync=%b clk=%b", i, state, accum_sync, pdm_clk);
      end
      tick();
    end
    checks++;
    if (state !== 2'd0 || busy !== 1'b0 || pdm_clk !== 1'b0 || pdm_sample_valid !== 1'b0 || accum_sync !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle state=%0d busy=%b clk=%b sv=%b sync=%b", state, busy, pdm_clk,
               pdm_sample_valid, accum_sync);
    end
    tick(3);
    checks++;
    if (pdm_clk !== 1'b0 || pdm_sample_valid !== 1'b0 || state !== 2'd0) begin
      errors++; $display("FAIL abort_parked clk=%b sv=%b state=%0d", pdm_clk, pdm_sample_valid, state);
    end
  endtask

  // Scenario 4: enable dropped then restored inside STOP, with a new rate.
  task automatic test_reenable;
    mode_req = 1'b0; enable = 1'b1;
    tick();
    tick(130);
    enable = 1'b0;
    tick();
    tick(5);
    enable = 1'b1; mode_req = 1'b1;
    tick();
    tick(118);
    checks++;
    if (state !== 2'd3) begin
      errors++; $display("FAIL reenable_stop state=%0d want 3", state);
    end
    tick();
    checks++;
    if (state !== 2'd1 || mode !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL reenable_warmup state=%0d mode=%b busy=%b want 1/1/1", state, mode, busy);
    end
    for (int k = 0; k < 256; k++) begin
      checks++;
      if (accum_sync !== 1'b0 || state !== 2'd1) begin
        errors++; $display("FAIL reenable_count k=%0d sync=%b state=%0d", k, accum_sync, state);
      end
      tick();
    end
    checks++;
    if (accum_sync !== 1'b1 || capture_en !== 1'b1) begin
      errors++; $display("FAIL reenable_sync sync=%b cap=%b want 1/1", accum_sync, capture_en);
    end
  endtask

  // Scenario 5: asynchronous reset between clock edges while in RUN.
  task automatic test_async_reset;
    tick(40);
    #2;
    rst_n = 1'b0;
    enable = 1'b0;
    #1;
    checks++;
    if ({pdm_clk, pdm_sample_valid, mode, accum_sync, capture_en, busy, state} !== 8'b0) begin
      errors++;
      $display("FAIL async_reset got=%b want=00000000",
               {pdm_clk, pdm_sample_valid, mode, accum_sync, capture_en, busy, state});
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick(5);
    checks++;
    if (state !== 2'd0 || busy !== 1'b0 || pdm_clk !== 1'b0) begin
      errors++; $display("FAIL async_release state=%0d busy=%b clk=%b", state, busy, pdm_clk);
    end
  endtask

  // Scenario 6: mode_req noise while disabled.
  task automatic test_idle_noise;
    enable = 1'b0;
    for (int i = 0; i < 20; i++) begin
      mode_req = ~mode_req;
      tick();
      checks++;
      if ({pdm_clk, pdm_sample_valid, mode, accum_sync, capture_en, busy, state} !== 8'b0) begin
        errors++;
        $display("FAIL idle_noise i=%0d got=%b want=00000000", i,
                 {pdm_clk, pdm_sample_valid, mode, accum_sync, capture_en, busy, state});
      end
    end
  endtask

  initial begin
    test_reset();
    test_start();
    test_rate_change();
    go_idle();
    test_abort();
    test_reenable();
    test_async_reset();
    test_idle_noise();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
